moore_counter_arbiter: RTL and testbench
========================================

MOORE_COUNTER_ARBITER -- requirements
Module: moore_counter_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter LEN_W, default 4: width of each per-requester enable-length field.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, N_REQ bits: level request, one bit per requester.
REQ-006 SHALL have port len, input, N_REQ*LEN_W bits: packed enable lengths; requester i occupies bits [i*LEN_W +: LEN_W].
REQ-007 SHALL have port y_in, input, 1 bit: terminal-state flag (state 11) from the shared 2-bit Moore counter.
REQ-008 SHALL have port gnt, output, N_REQ bits: one-hot grant to the current owner.
REQ-009 SHALL have port ctr_clr, output, 1 bit: one-cycle clear pulse to the shared counter.
REQ-010 SHALL have port x_en, output, 1 bit: count enable driven to the shared counter's x_in.
REQ-011 SHALL have port done, output, N_REQ bits: one-cycle completion pulse to the owner.
REQ-012 SHALL have port wraps, output, LEN_W bits: count of y_in-high cycles seen during the last RUN; holds until the next CLEAR.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, RUN and DONE; all outputs SHALL be registered.
REQ-015 IDLE: gnt=0, x_en=0, ctr_clr=0; with any req bit high, SHALL pick a winner per REQ-027/028, latch its len into rem, and go to CLEAR.
REQ-016 CLEAR (1 cycle): gnt=onehot(winner), ctr_clr=1, wraps cleared to 0; SHALL go to RUN if rem!=0, else to DONE.
REQ-017 RUN: gnt held, x_en=1; rem decrements each cycle; wraps increments on cycles with y_in=1 and saturates at all-ones; SHALL go to DONE in the cycle rem==1.
REQ-018 x_en SHALL be high for exactly len cycles, with no gaps.
REQ-019 DONE (1 cycle): x_en=0, gnt held, done[winner]=1; SHALL update the priority pointer and return to IDLE.
REQ-020 Latency: req high at edge t in IDLE -> ctr_clr and gnt at t+1, x_en from t+2 to t+1+len, done at t+2+len, IDLE at t+3+len.
REQ-021 Requests are committed: dropping req or changing len after the winner is latched SHALL NOT affect the transaction.
REQ-022 req bits arriving while busy SHALL be held off until IDLE; no request is lost while its level stays high.
REQ-023 len=0 SHALL give CLEAR then DONE, with no x_en pulse and wraps=0.
REQ-024 Back-to-back: the minimum gap between two grants SHALL be one IDLE cycle.

Reset
REQ-025 With rst=1 at an edge, SHALL set state=IDLE, gnt=0, ctr_clr=0, x_en=0, done=0, wraps=0, busy=0, rem=0, and priority pointer=0.
REQ-026 rst mid-RUN SHALL abort the transaction with no done pulse; the shared counter's state is not cleared by this block.

Configuration
REQ-027 With macro MCA_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: search starts at the pointer, and the pointer becomes winner+1 (mod N_REQ) in DONE.
REQ-028 Without MCA_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest index wins; the pointer register SHALL be absent or held at 0.

Verification
REQ-029 Reset, then req=0001 with len0=3 -> ctr_clr 1 cycle, x_en 3 cycles, done=0001 at t+5, busy low at t+6.
REQ-030 Counter model connected, len0=6 from cleared state 00 -> wraps=1; with len0=15 -> wraps=4.
REQ-031 req=1111 held with all len=1: under MCA_ROUND_ROBIN_EN the grant order SHALL be 0,1,2,3,0; without the macro the grant SHALL be 0 every time.
REQ-032 req=0100 with len2=0 -> gnt=0100 for 2 cycles, x_en never high, done=0100, wraps=0.
REQ-033 rst=1 in the 2nd RUN cycle of len=5 -> next cycle all outputs 0 and state IDLE; no done pulse.
REQ-034 req0 dropped during RUN with len0=4 -> x_en still high for 4 cycles and done=0001 still issued.

Source files
------------

// File: rtl/moore_counter_arbiter.sv
// Arbiter that hands a shared 2-bit Moore counter to one requester at a time.
// Define MCA_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module moore_counter_arbiter #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LEN_W-1:0]   len,
  input  logic                     y_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     ctr_clr,
  output logic                     x_en,
  output logic [N_REQ-1:0]         done,
  output logic [LEN_W-1:0]         wraps,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [IW-1:0]    pick;
  logic [IW:0]      idx;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] len_pick;
  logic             x_en_d;

  // First active requester at or after the pointer; lowest offset wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(N_REQ))
        idx = idx - (IW+1)'(N_REQ);
      if (req[idx[IW-1:0]])
        pick = idx[IW-1:0];
    end
  end

  // Enable length of the requester being picked.
  always_comb begin
    len_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i))
        len_pick = len[i*LEN_W +: LEN_W];
    end
  end

  // Transaction FSM with registered outputs.
  // The counter's y output trails each enabled count by one cycle, so
  // y_in is counted on the cycle after an x_en cycle (last RUN -> DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gnt     <= '0;
      ctr_clr <= 1'b0;
      x_en    <= 1'b0;
      done    <= '0;
      wraps   <= '0;
      busy    <= 1'b0;
      rem     <= '0;
      ptr     <= '0;
      win     <= '0;
      x_en_d  <= 1'b0;
    end else begin
      ctr_clr <= 1'b0;
      done    <= '0;
      x_en_d  <= x_en;
      if (x_en_d && y_in && wraps != '1)
        wraps <= wraps + LEN_W'(1);
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            state   <= S_CLEAR;
            win     <= pick;
            rem     <= len_pick;
            gnt     <= N_REQ'(1) << pick;
            ctr_clr <= 1'b1;
            wraps   <= '0;
            busy    <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (rem != '0) begin
            state <= S_RUN;
            x_en  <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= gnt;
          end
        end
        S_RUN: begin
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state <= S_DONE;
            x_en  <= 1'b0;
            done  <= gnt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
`ifdef MCA_ROUND_ROBIN_EN
          ptr   <= (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
`else
          ptr   <= '0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_moore_counter_arbiter.sv
// Randomized bench for moore_counter_arbiter with a shared 2-bit counter
// and a transaction-level expectation model.
module tb_moore_counter_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*LW-1:0] len;
  logic            y_in;
  logic [N-1:0]    gnt;
  logic            ctr_clr;
  logic            x_en;
  logic [N-1:0]    done;
  logic [LW-1:0]   wraps;
  logic            busy;
  logic [1:0]      cnt = 2'b00;

  int n_chk = 0;
  int n_err = 0;
  int mptr  = 0;

  moore_counter_arbiter #(.N_REQ(N), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .y_in(y_in),
    .gnt(gnt), .ctr_clr(ctr_clr), .x_en(x_en), .done(done),
    .wraps(wraps), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared 2-bit Moore counter; y is high in state 11.
  always_ff @(posedge clk) begin
    if (ctr_clr)   cnt <= 2'b00;
    else if (x_en) cnt <= cnt + 2'b01;
  end
  assign y_in = (cnt == 2'b11);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_w(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'(0));
    chk({tag, ".clr"}, 32'(ctr_clr), 32'(0));
    chk({tag, ".x_en"}, 32'(x_en), 32'(0));
    chk({tag, ".done"}, 32'(done), 32'(0));
    chk({tag, ".busy"}, 32'(busy), 32'(0));
  endtask

  // Called at a negedge while idle. mode: 0 hold, 1 random req/len, 2 drop req.
  task automatic txn(input logic [N-1:0] r, input logic [N*LW-1:0] l,
                     input int mode);
    int w;
    int el;
    int ew;
    logic [N-1:0] oh;
    req = r;
    len = l;
    w  = pick_w(r, mptr);
    el = int'((l >> (w * LW)) & 16'hF);
    ew = (el + 1) / 4;
    oh = N'(1) << w;
    @(posedge clk);
    for (int c = 1; c <= 3 + el; c++) begin
      @(negedge clk);
      chk("gnt", 32'(gnt), (c <= 2 + el) ? 32'(oh) : 32'(0));
      chk("ctr_clr", 32'(ctr_clr), 32'(c == 1));
      chk("x_en", 32'(x_en), 32'(c >= 2 && c <= 1 + el));
      chk("done", 32'(done), (c == 2 + el) ? 32'(oh) : 32'(0));
      chk("busy", 32'(busy), 32'(c <= 2 + el));
      if (c == 1)      chk("wraps_clr", 32'(wraps), 32'(0));
      if (c == 3 + el) chk("wraps", 32'(wraps), 32'(ew));
      if (mode == 1) begin
        req = N'($urandom);
        len = (N*LW)'($urandom);
      end else if (mode == 2) begin
        req = '0;
        len = (N*LW)'($urandom);
      end
    end
`ifdef MCA_ROUND_ROBIN_EN
    mptr = (w + 1) % N;
`endif
    req = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0;
    len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");
    chk("reset.wraps", 32'(wraps), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    idle_chk("post_reset");

    txn(4'b0001, 16'h0003, 0);
    txn(4'b0001, 16'h0006, 0);
    txn(4'b0001, 16'h000F, 0);
    for (int k = 0; k < 5; k++) txn(4'b1111, 16'h1111, 0);
    txn(4'b0100, 16'hF0FF, 0);
    txn(4'b0001, 16'h0004, 2);

    // Reset in the second RUN cycle of a len=5 transaction.
    req = 4'b0001;
    len = 16'h0005;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("rr.x_en", 32'(x_en), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    idle_chk("mid_rst");
    chk("mid_rst.wraps", 32'(wraps), 32'(0));
    rst = 1'b0;
    req = '0;
    mptr = 0;
    repeat (3) begin
      @(negedge clk);
      idle_chk("after_rst");
    end

    for (int k = 0; k < 40; k++) begin
      txn(N'($urandom_range(1, 15)), (N*LW)'($urandom),
          $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        idle_chk("gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
